// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART baud table, counter width and feeder FSM states
package uart_pkg;

    localparam int CNT_W = 18;

    // Divider per baud select; the transmitter indexes the same table.
    localparam logic [13:0] BAUD_DIV [0:7] = '{
        14'd2603, 14'd10415, 14'd5207, 14'd2603,
        14'd1301, 14'd650,   14'd433,  14'd216
    };

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT_OK,
        GAP
    } feeder_state_t;

    function automatic logic [CNT_W-1:0] bit_period(input logic [2:0] baud);
        return CNT_W'(BAUD_DIV[baud]) + CNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_feeder_if.sv
// rtl/uart_tx_feeder_if.sv - byte handshake between the feeder and the UART transmitter
interface uart_tx_feeder_if;

    logic [7:0] tx_dat;
    logic       tx_en;
    logic       tx_ing;
    logic       tx_ok;

    modport master (
        output tx_dat,
        output tx_en,
        input  tx_ing,
        input  tx_ok
    );

    modport slave (
        input  tx_dat,
        input  tx_en,
        output tx_ing,
        output tx_ok
    );

endinterface

// File: rtl/uart_sync_fifo.sv
// rtl/uart_sync_fifo.sv - DEPTH x DW synchronous FIFO with registered flags and flush
module uart_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 8
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          flush,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   lvl_nxt;
    logic          do_push;
    logic          do_pop;

    // Full is judged on the registered flag, so a pop in the same cycle cannot rescue a write.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign rdata   = mem[rd_ptr];

    always_comb begin
        lvl_nxt = level;
        if (do_push && !do_pop) begin
            lvl_nxt = level + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            lvl_nxt = level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= lvl_nxt;
            full  <= (lvl_nxt == (AW+1)'(DEPTH));
            empty <= (lvl_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - queues bytes and sequences them into the UART transmitter with stop-bit gaps
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int AW        = 4,
    parameter int STOP_BITS = 1,
    parameter int TMO_BITS  = 11
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              wr_en,
    input  logic [7:0]        wr_dat,
    input  logic              flush,
    input  logic [2:0]        tx_baud,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              overflow,
    output logic              tmo_err,
    output logic              busy,
    uart_tx_feeder_if.master  tx
);

    localparam logic [CNT_W-1:0] STOP_W = CNT_W'(STOP_BITS);
    localparam logic [CNT_W-1:0] TMO_W  = CNT_W'(TMO_BITS);

    feeder_state_t    state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] p_now;
    logic [CNT_W-1:0] gap_load;
    logic [CNT_W-1:0] tmo_lim;
    logic [7:0]       tx_dat_q;
    logic             tx_en_q;
    logic [7:0]       head;
    logic             pop;
    logic             unused_tx_ing;

    assign p_now    = bit_period(tx_baud);
    assign gap_load = STOP_W * p_now;
    assign tmo_lim  = TMO_W * period_q;
    assign pop      = (state_q == IDLE) && !empty && !flush;
    assign busy     = (state_q != IDLE) || !empty;

    assign tx.tx_dat     = tx_dat_q;
    assign tx.tx_en      = tx_en_q;
    assign unused_tx_ing = tx.tx_ing;

    uart_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (8)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .flush (flush),
        .push  (wr_en),
        .wdata (wr_dat),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            period_q <= '0;
            tx_dat_q <= 8'h00;
            tx_en_q  <= 1'b0;
            overflow <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;

            if (flush) begin
                overflow <= 1'b0;
                tmo_err  <= 1'b0;
            end else if (wr_en && full) begin
                overflow <= 1'b1;
            end

            // Flush never aborts a frame: the transmitter cannot be stopped once started.
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        tx_dat_q <= head;
                        tx_en_q  <= 1'b1;
                        state_q  <= START;
                    end
                end
                START: begin
                    cnt_q    <= '0;
                    period_q <= p_now;
                    state_q  <= WAIT_OK;
                end
                WAIT_OK: begin
                    if (tx.tx_ok) begin
                        cnt_q    <= gap_load;
                        period_q <= p_now;
                        state_q  <= GAP;
                    end else if (cnt_q + CNT_W'(1) == tmo_lim) begin
                        tmo_err  <= 1'b1;
                        cnt_q    <= gap_load;
                        period_q <= p_now;
                        state_q  <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - directed self-checking bench for uart_tx_feeder
module tb_uart_tx_feeder;

    localparam int P       = 217;
    localparam int SPACING = 11 * P + 3;

    logic       clk     = 1'b0;
    logic       rstn    = 1'b0;
    logic       wr_en   = 1'b0;
    logic [7:0] wr_dat  = 8'h00;
    logic       flush   = 1'b0;
    logic [2:0] tx_baud = 3'd7;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       overflow;
    logic       tmo_err;
    logic       busy;

    logic       man_ok  = 1'b0;
    logic       mdl_ok  = 1'b0;
    logic       auto_ok = 1'b0;

    int         n_cmp = 0;
    int         n_bad = 0;
    longint     cyc   = 0;
    logic [7:0] sent_q [$];
    longint     sent_t [$];

    uart_tx_feeder_if txif ();

    assign txif.tx_ok  = man_ok | mdl_ok;
    assign txif.tx_ing = 1'b0;

    uart_tx_feeder #(
        .DEPTH     (16),
        .AW        (4),
        .STOP_BITS (1),
        .TMO_BITS  (11)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .wr_en    (wr_en),
        .wr_dat   (wr_dat),
        .flush    (flush),
        .tx_baud  (tx_baud),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tmo_err  (tmo_err),
        .busy     (busy),
        .tx       (txif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (txif.tx_en) begin
            sent_q.push_back(txif.tx_dat);
            sent_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Transmitter stand-in: frame-done pulse 10 bit periods after the start pulse.
    initial begin
        logic [7:0] cap;
        forever begin
            @(negedge clk);
            if (auto_ok && txif.tx_en) begin
                cap = txif.tx_dat;
                repeat (10 * P) @(negedge clk);
                check("hold_dat", {24'd0, txif.tx_dat}, {24'd0, cap});
                mdl_ok = 1'b1;
                @(negedge clk);
                mdl_ok = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int n0;

        repeat (3) @(negedge clk);
        check("rst_tx_en",    {31'd0, txif.tx_en}, 32'd0);
        check("rst_tx_dat",   {24'd0, txif.tx_dat}, 32'd0);
        check("rst_empty",    {31'd0, empty}, 32'd1);
        check("rst_full",     {31'd0, full}, 32'd0);
        check("rst_level",    {27'd0, level}, 32'd0);
        check("rst_overflow", {31'd0, overflow}, 32'd0);
        check("rst_tmo",      {31'd0, tmo_err}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single byte into an empty FIFO
        wr_en = 1'b1; wr_dat = 8'hA5;
        @(negedge clk);
        wr_en = 1'b0;
        check("wr_empty", {31'd0, empty}, 32'd0);
        check("wr_level", {27'd0, level}, 32'd1);
        check("wr_no_en", {31'd0, txif.tx_en}, 32'd0);
        @(negedge clk);
        check("start_en",  {31'd0, txif.tx_en}, 32'd1);
        check("start_dat", {24'd0, txif.tx_dat}, 32'h0000_00A5);
        check("pop_level", {27'd0, level}, 32'd0);
        @(negedge clk);
        check("en_pulse", {31'd0, txif.tx_en}, 32'd0);

        // Burst of 16 while the first frame is still waiting for tx_ok
        for (int i = 1; i <= 16; i++) begin
            wr_en = 1'b1; wr_dat = 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("burst_full",  {31'd0, full}, 32'd1);
        check("burst_level", {27'd0, level}, 32'd16);
        check("burst_ovf",   {31'd0, overflow}, 32'd0);
        check("burst_hold",  {24'd0, txif.tx_dat}, 32'h0000_00A5);

        // tx_ok, stop gap, then a write that lands on the pop edge while full
        man_ok = 1'b1;
        @(negedge clk);
        man_ok = 1'b0;
        repeat (P) @(negedge clk);
        check("gap_no_en",  {31'd0, txif.tx_en}, 32'd0);
        @(negedge clk);
        check("idle_no_en", {31'd0, txif.tx_en}, 32'd0);
        check("idle_level", {27'd0, level}, 32'd16);
        wr_en = 1'b1; wr_dat = 8'hFF; auto_ok = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        check("sim_en",    {31'd0, txif.tx_en}, 32'd1);
        check("sim_dat",   {24'd0, txif.tx_dat}, 32'h0000_0001);
        check("sim_level", {27'd0, level}, 32'd15);
        check("sim_ovf",   {31'd0, overflow}, 32'd1);
        check("sim_full",  {31'd0, full}, 32'd0);

        w = 0;
        while ((sent_q.size() < 17 || busy) && w < 45000) begin
            @(negedge clk);
            w++;
        end
        auto_ok = 1'b0;
        check("burst_done", {31'd0, (w < 45000)}, 32'd1);
        check("sent_count", sent_q.size(), 32'd17);
        check("sent_0", {24'd0, sent_q[0]}, 32'h0000_00A5);
        for (int i = 1; i <= 16; i++) begin
            check($sformatf("sent_%0d", i), {24'd0, sent_q[i]}, i);
        end
        for (int i = 1; i < 16; i++) begin
            check($sformatf("spacing_%0d", i), 32'(sent_t[i+1] - sent_t[i]), SPACING);
        end

        // Flush clears the sticky flag and drops a simultaneous write
        check("ovf_sticky", {31'd0, overflow}, 32'd1);
        flush = 1'b1; wr_en = 1'b1; wr_dat = 8'h55;
        @(negedge clk);
        flush = 1'b0; wr_en = 1'b0;
        check("flush_ovf",   {31'd0, overflow}, 32'd0);
        check("flush_level", {27'd0, level}, 32'd0);
        check("flush_empty", {31'd0, empty}, 32'd1);
        @(negedge clk);
        check("flush_no_en", {31'd0, txif.tx_en}, 32'd0);
        check("flush_busy",  {31'd0, busy}, 32'd0);

        // Timeout with tx_ok held low
        wr_en = 1'b1; wr_dat = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check("tmo_start", {31'd0, txif.tx_en}, 32'd1);
        repeat (11 * P) @(negedge clk);
        check("tmo_early", {31'd0, tmo_err}, 32'd0);
        check("tmo_busy",  {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("tmo_set",   {31'd0, tmo_err}, 32'd1);
        check("tmo_dat",   {24'd0, txif.tx_dat}, 32'h0000_003C);
        repeat (P) @(negedge clk);
        check("tmo_gap",   {31'd0, busy}, 32'd1);
        @(negedge clk);
        check("tmo_idle",  {31'd0, busy}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("tmo_flush", {31'd0, tmo_err}, 32'd0);

        // Reset during WAIT_OK with 5 bytes queued
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_dat = 8'h11 + 8'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_rst_level", {27'd0, level}, 32'd5);
        check("pre_rst_dat",   {24'd0, txif.tx_dat}, 32'h0000_0011);
        n0 = sent_q.size();
        rstn = 1'b0;
        #1;
        check("mid_rst_en",    {31'd0, txif.tx_en}, 32'd0);
        check("mid_rst_dat",   {24'd0, txif.tx_dat}, 32'd0);
        check("mid_rst_level", {27'd0, level}, 32'd0);
        check("mid_rst_empty", {31'd0, empty}, 32'd1);
        check("mid_rst_busy",  {31'd0, busy}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (20) @(negedge clk);
        check("post_rst_quiet", sent_q.size(), n0);
        check("post_rst_busy",  {31'd0, busy}, 32'd0);
        wr_en = 1'b1; wr_dat = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        @(negedge clk);
        check("post_rst_en",  {31'd0, txif.tx_en}, 32'd1);
        check("post_rst_dat", {24'd0, txif.tx_dat}, 32'h0000_0077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
